// File: rtl/ship_mover.sv
// Player-ship column controller. A tap moves one step, and a held button auto-repeats after a delay.
// The screen edges either saturate or wrap to the opposite edge.
module ship_mover #(
    parameter int X_WIDTH      = 5,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 19,
    parameter int X_RESET      = 5,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 4,
    parameter int REPEAT_RATE  = 2,
    parameter int WRAP         = 0
) (
    input  logic               clk_12MHz,
    input  logic               reset,
    input  logic               left_debounced,
    input  logic               right_debounced,
    input  logic               enable,
    output logic [X_WIDTH-1:0] ship_x,
    output logic               at_min,
    output logic               at_max,
    output logic               moved
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   DELAY_END  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]   RATE_END   = CNT_W'(REPEAT_RATE);
    localparam logic [X_WIDTH:0]   STEP_W     = (X_WIDTH+1)'(STEP);
    localparam logic [X_WIDTH:0]   LEFT_FLOOR = (X_WIDTH+1)'(X_MIN + STEP);
    localparam logic [X_WIDTH:0]   MAX_W      = (X_WIDTH+1)'(X_MAX);
    localparam logic [X_WIDTH-1:0] MIN_X      = X_WIDTH'(X_MIN);
    localparam logic [X_WIDTH-1:0] MAX_X      = X_WIDTH'(X_MAX);
    localparam logic [X_WIDTH-1:0] RESET_X    = X_WIDTH'(X_RESET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_t;

    state_t             state_q, state_d;
    dir_t               last_dir_q, last_dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [X_WIDTH-1:0] ship_x_q, ship_x_d;
    logic               moved_q, moved_d;

    dir_t               dir;
    logic               do_move;
    logic [CNT_W-1:0]   cnt_inc;
    logic [X_WIDTH:0]   x_wide, diff_left, sum_right;
    logic [X_WIDTH-1:0] x_left, x_right, x_target;

    always_comb begin
        dir = DIR_NONE;
        if (left_debounced && !right_debounced) begin
            dir = DIR_LEFT;
        end else if (right_debounced && !left_debounced) begin
            dir = DIR_RIGHT;
        end
    end

    // Arithmetic is done one bit wider so neither direction can wrap around the register width.
    always_comb begin
        x_wide    = {1'b0, ship_x_q};
        diff_left = x_wide - STEP_W;
        sum_right = x_wide + STEP_W;

        x_left = MIN_X;
        if (x_wide >= LEFT_FLOOR) begin
            x_left = diff_left[X_WIDTH-1:0];
        end
        if ((WRAP != 0) && (ship_x_q == MIN_X)) begin
            x_left = MAX_X;
        end

        x_right = MAX_X;
        if (sum_right <= MAX_W) begin
            x_right = sum_right[X_WIDTH-1:0];
        end
        if ((WRAP != 0) && (ship_x_q == MAX_X)) begin
            x_right = MIN_X;
        end

        x_target = (dir == DIR_LEFT) ? x_left : x_right;
    end

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        cnt_d      = cnt_q;
        do_move    = 1'b0;
        cnt_inc    = cnt_q + CNT_W'(1);

        if (enable) begin
            if (state_q == S_IDLE) begin
                if (dir != DIR_NONE) begin
                    do_move    = 1'b1;
                    state_d    = S_DELAY;
                    cnt_d      = '0;
                    last_dir_d = dir;
                end
            end else if (dir == DIR_NONE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (dir != last_dir_q) begin
                // A reversal restarts the hold as if the button were newly pressed.
                do_move    = 1'b1;
                state_d    = S_DELAY;
                cnt_d      = '0;
                last_dir_d = dir;
            end else if (state_q == S_DELAY) begin
                if (cnt_inc == DELAY_END) begin
                    do_move = 1'b1;
                    state_d = S_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                if (cnt_inc == RATE_END) begin
                    do_move = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end

        ship_x_d = do_move ? x_target : ship_x_q;
        moved_d  = do_move && (x_target != ship_x_q);
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_dir_q <= DIR_NONE;
            cnt_q      <= '0;
            ship_x_q   <= RESET_X;
            moved_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            cnt_q      <= cnt_d;
            ship_x_q   <= ship_x_d;
            moved_q    <= moved_d;
        end
    end

    assign ship_x = ship_x_q;
    assign moved  = moved_q;
    assign at_min = (ship_x_q == MIN_X);
    assign at_max = (ship_x_q == MAX_X);

endmodule

// File: tb/tb_ship_mover.sv
// Bench for ship_mover: a saturating and a wrapping instance share stimulus and are checked every
// cycle against a hold-duration model, plus literal checkpoints from the directed scenarios.
module tb_ship_mover;

    localparam int XW = 5;
    localparam int XMIN = 0;
    localparam int XMAX = 19;
    localparam int XRST = 5;
    localparam int STP = 1;
    localparam int RDLY = 4;
    localparam int RRATE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left = 1'b0;
    logic right = 1'b0;
    logic enable = 1'b0;

    logic [XW-1:0] x_sat, x_wr;
    logic          amin_sat, amax_sat, mv_sat;
    logic          amin_wr, amax_wr, mv_wr;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    ship_mover #(.X_WIDTH(XW), .X_MIN(XMIN), .X_MAX(XMAX), .X_RESET(XRST), .STEP(STP),
                 .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .WRAP(0)) u_sat (
        .clk_12MHz(clk), .reset(reset), .left_debounced(left), .right_debounced(right),
        .enable(enable), .ship_x(x_sat), .at_min(amin_sat), .at_max(amax_sat), .moved(mv_sat));

    ship_mover #(.X_WIDTH(XW), .X_MIN(XMIN), .X_MAX(XMAX), .X_RESET(XRST), .STEP(STP),
                 .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .WRAP(1)) u_wrap (
        .clk_12MHz(clk), .reset(reset), .left_debounced(left), .right_debounced(right),
        .enable(enable), .ship_x(x_wr), .at_min(amin_wr), .at_max(amax_wr), .moved(mv_wr));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a move fires on the 1st tick of a hold, then on tick RDLY+1, then every RRATE ticks.
    int exp_x[2];
    int exp_mv[2];
    int hold_k = 0;
    int hold_dir = 0;
    bit model_ok = 1'b0;

    function automatic int step_pos(input int x, input int d, input int wrap);
        int r;
        if (d == 1) begin
            if (wrap != 0 && x == XMIN) r = XMAX;
            else r = (x - STP < XMIN) ? XMIN : x - STP;
        end else begin
            if (wrap != 0 && x == XMAX) r = XMIN;
            else r = (x + STP > XMAX) ? XMAX : x + STP;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int d;
        bit fire;
        int nx;
        if (reset) begin
            model_ok = 1'b1;
            hold_k = 0;
            hold_dir = 0;
            for (int i = 0; i < 2; i++) begin
                exp_x[i] = XRST;
                exp_mv[i] = 0;
            end
        end else if (!enable) begin
            for (int i = 0; i < 2; i++) exp_mv[i] = 0;
        end else begin
            d = (left && !right) ? 1 : ((right && !left) ? 2 : 0);
            fire = 1'b0;
            if (d == 0) begin
                hold_k = 0;
                hold_dir = 0;
            end else begin
                if (d != hold_dir) begin
                    hold_k = 1;
                    hold_dir = d;
                end else begin
                    hold_k++;
                end
                fire = (hold_k == 1) || (hold_k > RDLY && ((hold_k - 1 - RDLY) % RRATE) == 0);
            end
            for (int i = 0; i < 2; i++) begin
                exp_mv[i] = 0;
                if (fire) begin
                    nx = step_pos(exp_x[i], d, i);
                    exp_mv[i] = (nx != exp_x[i]) ? 1 : 0;
                    exp_x[i] = nx;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("sat.ship_x", int'(x_sat), exp_x[0]);
            chk("sat.moved", int'(mv_sat), exp_mv[0]);
            chk("sat.at_min", int'(amin_sat), (exp_x[0] == XMIN) ? 1 : 0);
            chk("sat.at_max", int'(amax_sat), (exp_x[0] == XMAX) ? 1 : 0);
            chk("wrap.ship_x", int'(x_wr), exp_x[1]);
            chk("wrap.moved", int'(mv_wr), exp_mv[1]);
            chk("wrap.at_min", int'(amin_wr), (exp_x[1] == XMIN) ? 1 : 0);
            chk("wrap.at_max", int'(amax_wr), (exp_x[1] == XMAX) ? 1 : 0);
        end
        if (mv_sat) pulse_cnt++;
    end

    // Each tick: buttons held, three idle clocks, then one clock with enable high.
    task automatic ticks(input logic l, input logic r, input int n);
        repeat (n) begin
            left = l;
            right = r;
            enable = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #2;
            end
            enable = 1'b1;
            @(posedge clk);
            #2;
            enable = 1'b0;
        end
    endtask

    task automatic do_reset();
        left = 1'b0;
        right = 1'b0;
        enable = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        pulse_cnt = 0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        do_reset();
        chk("reset.ship_x", int'(x_sat), 5);
        chk("reset.moved", int'(mv_sat), 0);

        // Single left tap
        ticks(1'b1, 1'b0, 1);
        chk("t1.ship_x", int'(x_sat), 4);
        chk("t1.at_min", int'(amin_sat), 0);
        ticks(1'b0, 1'b0, 1);
        chk("t1.pulses", pulse_cnt, 1);
        $display("t1 tap left: ship_x=%0d pulses=%0d", x_sat, pulse_cnt);

        // Hold right for 10 ticks: moves on ticks 1,5,7,9
        do_reset();
        ticks(1'b0, 1'b1, 10);
        chk("t2.ship_x", int'(x_sat), 9);
        chk("t2.pulses", pulse_cnt, 4);
        $display("t2 hold right: ship_x=%0d pulses=%0d", x_sat, pulse_cnt);

        // Hold left 30 ticks: saturating instance clamps at 0 after 5 moves
        do_reset();
        ticks(1'b1, 1'b0, 30);
        chk("t3.ship_x", int'(x_sat), 0);
        chk("t3.at_min", int'(amin_sat), 1);
        chk("t3.pulses", pulse_cnt, 5);
        $display("t3 hold left: ship_x=%0d pulses=%0d", x_sat, pulse_cnt);

        // Wrapping instance: reach 0, release, tap left -> 19
        do_reset();
        ticks(1'b1, 1'b0, 11);
        ticks(1'b0, 1'b0, 1);
        chk("t3w.at0", int'(x_wr), 0);
        ticks(1'b1, 1'b0, 1);
        chk("t3w.ship_x", int'(x_wr), 19);
        chk("t3w.at_max", int'(amax_wr), 1);
        chk("t3w.moved", int'(mv_wr), 1);
        chk("t3w.sat_x", int'(x_sat), 0);
        chk("t3w.sat_moved", int'(mv_sat), 0);
        $display("t3w wrap tap: wrap_x=%0d sat_x=%0d", x_wr, x_sat);

        // Both buttons: no motion; then release left -> immediate move
        do_reset();
        ticks(1'b1, 1'b1, 5);
        chk("t4.both", int'(x_sat), 5);
        ticks(1'b0, 1'b1, 1);
        chk("t4.ship_x", int'(x_sat), 6);
        chk("t4.moved", int'(mv_sat), 1);
        $display("t4 both then right: ship_x=%0d", x_sat);

        // Reversal out of REPEAT, then the fresh 4-tick delay, then enable held low
        do_reset();
        ticks(1'b0, 1'b1, 6);
        chk("t5.repeat", int'(x_sat), 7);
        ticks(1'b1, 1'b0, 1);
        chk("t5.reverse", int'(x_sat), 6);
        ticks(1'b1, 1'b0, 3);
        chk("t5.delay", int'(x_sat), 6);
        ticks(1'b1, 1'b0, 1);
        chk("t5.rep1", int'(x_sat), 5);
        enable = 1'b0;
        left = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #2;
        end
        chk("t5.hold_x", int'(x_sat), 5);
        chk("t5.hold_mv", int'(mv_sat), 0);
        $display("t5 reversal: ship_x=%0d", x_sat);

        // Reset mid-REPEAT with right held and enable high
        ticks(1'b0, 1'b1, 6);
        chk("t6.pre", int'(x_sat), 7);
        reset = 1'b1;
        enable = 1'b1;
        right = 1'b1;
        @(posedge clk);
        #2;
        chk("t6.reset_x", int'(x_sat), 5);
        chk("t6.reset_mv", int'(mv_sat), 0);
        reset = 1'b0;
        enable = 1'b0;
        ticks(1'b0, 1'b1, 1);
        chk("t6.fresh", int'(x_sat), 6);
        chk("t6.fresh_mv", int'(mv_sat), 1);
        $display("t6 reset in repeat: ship_x=%0d", x_sat);

        ticks(1'b0, 1'b0, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ship_mover.md
Name: ship_mover

Overview:
Parametrised player-ship horizontal position controller with hold-to-repeat. It consumes debounced left/right buttons and a game-tick enable, and produces the ship column for the renderer and collision logic. A tap moves the ship one step; a held button auto-repeats after a programmable delay. The far edges either saturate or wrap, selected by parameter.

Parameters:
X_WIDTH, 5, width of position output
X_MIN, 0, leftmost legal column
X_MAX, 19, rightmost legal column (must be < 2^X_WIDTH)
X_RESET, 5, column after reset (X_MIN <= X_RESET <= X_MAX)
STEP, 1, columns moved per move event (>= 1)
REPEAT_DELAY, 4, enable ticks from first move to first auto-repeat (>= 1)
REPEAT_RATE, 2, enable ticks between subsequent auto-repeats (>= 1)
WRAP, 0, 0 = saturate at edges, 1 = jump to opposite edge when pushed past one

Ports:
clk_12MHz  in  1  system clock
reset  in  1  synchronous, active-high
left_debounced  in  1  debounced left button
right_debounced  in  1  debounced right button
enable  in  1  game-tick strobe; all state advances only on cycles with enable=1
ship_x  out  X_WIDTH  current ship column, registered
at_min  out  1  ship_x == X_MIN, combinational from ship_x
at_max  out  1  ship_x == X_MAX, combinational from ship_x
moved  out  1  registered one-cycle pulse, high the cycle after ship_x changed

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk_12MHz.
- Reset (priority over everything, including mid-repeat): ship_x=X_RESET, state=IDLE, hold counter=0, last_dir=none, moved=0.
- Direction decode: L = left & ~right; R = right & ~left; N = neither or both.
- enable=0: state, counter, last_dir and ship_x hold; moved=0.
- FSM states: IDLE, DELAY, REPEAT. Hold counter width is clog2(max(REPEAT_DELAY,REPEAT_RATE))+1.
- IDLE, enable=1, dir != N: issue a move in dir; go to DELAY; cnt=0; last_dir=dir.
- IDLE, enable=1, dir = N: stay in IDLE.
- DELAY/REPEAT, enable=1, dir = N: go to IDLE; cnt=0; no move.
- DELAY/REPEAT, enable=1, dir != last_dir (direction reversal): treat as a fresh press. Issue a move, go to DELAY, cnt=0, last_dir=dir.
- DELAY, same dir: if cnt+1 == REPEAT_DELAY, issue a move, go to REPEAT, cnt=0; otherwise cnt=cnt+1.
- REPEAT, same dir: if cnt+1 == REPEAT_RATE, issue a move, cnt=0; otherwise cnt=cnt+1.
- Move left, WRAP=0: ship_x = max(ship_x-STEP, X_MIN). Compute without underflow, i.e. compare ship_x against X_MIN+STEP first.
- Move right, WRAP=0: ship_x = min(ship_x+STEP, X_MAX). Compute at X_WIDTH+1 bits.
- WRAP=1: if already at the edge being pushed (X_MIN going left, X_MAX going right), jump to the opposite edge. Otherwise apply the saturating step above.
- moved=1 on the cycle following a move only if ship_x actually changed. Clamped no-op moves at the edge give moved=0 and leave the FSM timing unaffected.
- Latency: ship_x updates on the clock edge that samples enable=1; the same edge registers moved.

Test Plan (default parameters unless noted):
1. Reset, then left=1 for exactly one enable tick -> ship_x 5->4, moved pulses once, at_min=0.
2. From 5, hold right for 10 consecutive enable ticks (enable every 4th clock) -> moves on ticks 1,5,7,9; ship_x=9; exactly 4 moved pulses.
3. From 5, hold left for 30 ticks -> ship_x reaches 0 and stays 0; at_min=1; no moved pulse once clamped. Rerun with WRAP=1: 0 followed by a left tap -> 19, at_max=1, moved=1.
4. Both buttons high for 5 ticks -> ship_x unchanged, FSM in IDLE. Then release left while right stays held -> immediate move to 6.
5. Hold right into REPEAT state, then switch to left -> immediate left move on the reversal tick, followed by 4-tick delay spacing again. Hold with enable=0 for 20 clocks -> no change.
6. Assert reset during REPEAT with right held -> ship_x=5 next cycle, moved=0. First enable tick after reset release moves to 6, treated as a fresh press.
